// File: rtl/braille_pkg.sv
// Shared types and the ASCII-to-Braille lookup for the Braille cell driver.
// Dot k+1 of a cell is bit k; dots 1-3 are the left column, 4-6 the right.
package braille_pkg;

    typedef logic [5:0] dots_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_GAP
    } state_e;

    typedef struct packed {
        logic  valid;
        dots_t dots;
    } cell_t;

    function automatic cell_t ascii_to_braille(input logic [7:0] ch);
        logic [7:0] lc;
        cell_t      c;
        lc      = ((ch >= 8'h41) && (ch <= 8'h5A)) ? (ch | 8'h20) : ch;
        c.valid = 1'b1;
        case (lc)
            8'h61:   c.dots = 6'b000001;
            8'h62:   c.dots = 6'b000011;
            8'h63:   c.dots = 6'b001001;
            8'h64:   c.dots = 6'b011001;
            8'h65:   c.dots = 6'b010001;
            8'h66:   c.dots = 6'b001011;
            8'h67:   c.dots = 6'b011011;
            8'h68:   c.dots = 6'b010011;
            8'h69:   c.dots = 6'b001010;
            8'h6A:   c.dots = 6'b011010;
            8'h6B:   c.dots = 6'b000101;
            8'h6C:   c.dots = 6'b000111;
            8'h6D:   c.dots = 6'b001101;
            8'h6E:   c.dots = 6'b011101;
            8'h6F:   c.dots = 6'b010101;
            8'h70:   c.dots = 6'b001111;
            8'h71:   c.dots = 6'b011111;
            8'h72:   c.dots = 6'b010111;
            8'h73:   c.dots = 6'b001110;
            8'h74:   c.dots = 6'b011110;
            8'h75:   c.dots = 6'b100101;
            8'h76:   c.dots = 6'b100111;
            8'h77:   c.dots = 6'b111010;
            8'h78:   c.dots = 6'b101101;
            8'h79:   c.dots = 6'b111101;
            8'h7A:   c.dots = 6'b110101;
            default: begin
                c.valid = 1'b0;
                c.dots  = 6'b000000;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/braille_char_fifo.sv
// Synchronous letter FIFO; a push while full is accepted when a pop happens
// in the same cycle, since the popped slot is the one being overwritten.
module braille_char_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             accept,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign accept  = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(accept) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/braille_cell_driver.sv
// Consumes classifier letters, queues them and shows each as a Braille cell
// for HOLD_CYCLES followed by a blank gap of GAP_CYCLES.
module braille_cell_driver
    import braille_pkg::*;
#(
    parameter  int FIFO_DEPTH  = 4,
    parameter  int HOLD_CYCLES = 50_000_000,
    parameter  int GAP_CYCLES  = 10_000_000,
    localparam int CNT_BW      = $clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1),
    localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [7:0] i_alpha,
    output logic [5:0] o_dots,
    output logic       o_dot_en,
    output logic       o_char_done,
    output logic       o_busy,
    output logic       o_bad_char,
    output logic       o_overflow
);

    localparam logic [CNT_BW-1:0] HOLD_LAST = CNT_BW'(HOLD_CYCLES - 1);
    localparam logic [CNT_BW-1:0] GAP_LAST  = CNT_BW'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_BW-1:0] timer_q, timer_d;
    dots_t             pattern_q, pattern_d;

    dots_t dots_q, dots_d;
    logic  dot_en_q, dot_en_d;
    logic  char_done_q, char_done_d;
    logic  busy_q, busy_d;
    logic  bad_char_q, bad_char_d;
    logic  overflow_q, overflow_d;

    logic [7:0]    fifo_rd_data;
    logic          fifo_accept;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic          fifo_pop;
    cell_t         head_cell;

    braille_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (i_valid),
        .wr_data (i_alpha),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .accept  (fifo_accept),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign fifo_pop   = (state_q == ST_LOAD);
    assign head_cell  = ascii_to_braille(fifo_rd_data);
    assign count_next = fifo_count + CW'(fifo_accept) - CW'(fifo_pop && !fifo_empty);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            pattern_q   <= '0;
            dots_q      <= '0;
            dot_en_q    <= 1'b0;
            char_done_q <= 1'b0;
            busy_q      <= 1'b0;
            bad_char_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pattern_q   <= pattern_d;
            dots_q      <= dots_d;
            dot_en_q    <= dot_en_d;
            char_done_q <= char_done_d;
            busy_q      <= busy_d;
            bad_char_q  <= bad_char_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pattern_d = pattern_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d   = ST_HOLD;
                timer_d   = HOLD_LAST;
                pattern_d = head_cell.dots;
            end
            ST_HOLD: begin
                if (timer_q == '0) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LAST;
                end else begin
                    timer_d = timer_q - CNT_BW'(1);
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    state_d = fifo_empty ? ST_IDLE : ST_LOAD;
                end else begin
                    timer_d = timer_q - CNT_BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so the registered outputs
    // line up with the state they describe rather than lagging it by a cycle.
    always_comb begin
        dot_en_d    = (state_d == ST_HOLD);
        dots_d      = dot_en_d ? pattern_d : '0;
        char_done_d = dot_en_d && (timer_d == '0);
        bad_char_d  = (state_d == ST_LOAD) && !head_cell.valid;
        busy_d      = (state_d != ST_IDLE) || (count_next != '0);
        overflow_d  = overflow_q || (i_valid && !fifo_accept);
    end

    assign o_dots      = dots_q;
    assign o_dot_en    = dot_en_q;
    assign o_char_done = char_done_q;
    assign o_busy      = busy_q;
    assign o_bad_char  = bad_char_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_braille_cell_driver.sv
// Self-checking bench for braille_cell_driver with short hold/gap times;
// a negedge monitor turns the output stream into per-cell records.
module tb_braille_cell_driver;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int GAP   = 4;
    localparam int BASE_DOTS [10] = '{1, 12, 14, 145, 15, 124, 1245, 125, 24, 245};

    typedef struct {
        logic [5:0] dots;
        int         hold;
        bit         stable;
        int         done_cnt;
        bit         done_last;
        int         start_edge;
    } cell_rec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_alpha = 8'h00;
    logic [5:0] o_dots;
    logic       o_dot_en;
    logic       o_char_done;
    logic       o_busy;
    logic       o_bad_char;
    logic       o_overflow;

    int tests_run = 0;
    int tests_failed = 0;
    int edge_cnt = 0;

    cell_rec_t cells[$];
    cell_rec_t cur;
    bit        prev_en = 1'b0;
    bit        prev_bad = 1'b0;
    bit        prev_busy = 1'b0;
    int        bad_cnt = 0;
    int        bad_edge = 0;
    int        bad_run = 0;
    int        bad_len_max = 0;
    int        busy_fall_edge = 0;
    int        blank_errs = 0;

    braille_cell_driver #(
        .FIFO_DEPTH  (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_valid     (i_valid),
        .i_alpha     (i_alpha),
        .o_dots      (o_dots),
        .o_dot_en    (o_dot_en),
        .o_char_done (o_char_done),
        .o_busy      (o_busy),
        .o_bad_char  (o_bad_char),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference Braille: ten base cells built from dot numbers, the second
    // decade adds dot 3, the third adds dots 3 and 6, and 'w' is j plus dot 6.
    function automatic logic [6:0] ref_cell(input logic [7:0] b);
        int         idx;
        int         r;
        int         n;
        logic [5:0] d;
        if (b >= 8'h41 && b <= 8'h5A)      idx = int'(b) - 32'h41;
        else if (b >= 8'h61 && b <= 8'h7A) idx = int'(b) - 32'h61;
        else return 7'b0;
        d = 6'b0;
        if (idx == 22) begin
            n = 2456;
        end else begin
            r = (idx > 22) ? idx - 1 : idx;
            n = BASE_DOTS[r % 10];
            if (r >= 10) n = n * 10 + 3;
            if (r >= 20) n = n * 10 + 6;
        end
        while (n > 0) begin
            d[(n % 10) - 1] = 1'b1;
            n = n / 10;
        end
        return {1'b1, d};
    endfunction

    always @(negedge clk) begin
        if (o_dot_en) begin
            if (!prev_en) begin
                cur.dots       = o_dots;
                cur.hold       = 0;
                cur.stable     = 1'b1;
                cur.done_cnt   = 0;
                cur.start_edge = edge_cnt;
            end
            cur.hold++;
            if (o_dots !== cur.dots) cur.stable = 1'b0;
            if (o_char_done) cur.done_cnt++;
            cur.done_last = o_char_done;
        end else begin
            if (prev_en) cells.push_back(cur);
            if (o_dots !== 6'b0 || o_char_done) blank_errs++;
        end
        if (o_bad_char) begin
            if (!prev_bad) begin
                bad_cnt++;
                bad_edge = edge_cnt;
                bad_run  = 0;
            end
            bad_run++;
            if (bad_run > bad_len_max) bad_len_max = bad_run;
        end
        if (prev_busy && !o_busy) busy_fall_edge = edge_cnt;
        prev_en   = o_dot_en;
        prev_bad  = o_bad_char;
        prev_busy = o_busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cells.delete();
        bad_cnt        = 0;
        bad_edge       = 0;
        bad_len_max    = 0;
        busy_fall_edge = 0;
        blank_errs     = 0;
    endtask

    task automatic push_bytes(input logic [7:0] q[$], output int first_edge);
        first_edge = edge_cnt + 1;
        foreach (q[i]) begin
            i_valid = 1'b1;
            i_alpha = q[i];
            tick();
        end
        i_valid = 1'b0;
        i_alpha = 8'h00;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        tick();
        while (o_busy && k < budget) begin
            tick();
            k++;
        end
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wait_idle: o_busy=%0b after %0d cycles, expected 0", o_busy, budget);
        end
    endtask

    task automatic wait_en(input int budget);
        int k = 0;
        while (!o_dot_en && k < budget) begin
            tick();
            k++;
        end
        tests_run++;
        if (o_dot_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wait_en: o_dot_en=%0b after %0d cycles, expected 1", o_dot_en, budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({o_dots, o_dot_en, o_char_done, o_busy, o_bad_char, o_overflow} !== 11'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: outputs=%b expected 0", {o_dots, o_dot_en, o_char_done, o_busy, o_bad_char, o_overflow});
        end
        reset_n = 1'b1;
        repeat (2) tick();
        tests_run++;
        if ({o_dots, o_dot_en, o_char_done, o_busy, o_bad_char, o_overflow} !== 11'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: outputs=%b expected 0", {o_dots, o_dot_en, o_char_done, o_busy, o_bad_char, o_overflow});
        end
    endtask

    task automatic test_single_cell(input logic [7:0] b);
        logic [6:0] exp;
        logic [7:0] q[$];
        int         n;
        exp = ref_cell(b);
        q.push_back(b);
        clear_mon();
        push_bytes(q, n);
        wait_idle(100);
        tests_run++;
        if (cells.size() !== 1) begin
            tests_failed++;
            $display("[TB] FAIL single_count(%h): got %0d cells expected 1", b, cells.size());
        end else begin
            tests_run++;
            if (cells[0].dots !== exp[5:0] || !cells[0].stable) begin
                tests_failed++;
                $display("[TB] FAIL single_dots(%h): got %b stable=%0b expected %b", b, cells[0].dots, cells[0].stable, exp[5:0]);
            end
            tests_run++;
            if (cells[0].hold !== HOLD) begin
                tests_failed++;
                $display("[TB] FAIL single_hold(%h): got %0d expected %0d", b, cells[0].hold, HOLD);
            end
            tests_run++;
            if (cells[0].done_cnt !== 1 || !cells[0].done_last) begin
                tests_failed++;
                $display("[TB] FAIL single_done(%h): got %0d pulses last=%0b expected 1 on last cycle", b, cells[0].done_cnt, cells[0].done_last);
            end
            tests_run++;
            if (cells[0].start_edge - n !== 2) begin
                tests_failed++;
                $display("[TB] FAIL single_latency(%h): got %0d edges expected 2", b, cells[0].start_edge - n);
            end
        end
        tests_run++;
        if (busy_fall_edge - n !== 2 + HOLD + GAP) begin
            tests_failed++;
            $display("[TB] FAIL single_busy_fall(%h): got %0d edges expected %0d", b, busy_fall_edge - n, 2 + HOLD + GAP);
        end
        tests_run++;
        if (blank_errs !== 0) begin
            tests_failed++;
            $display("[TB] FAIL single_blank(%h): got %0d non-blank cycles outside hold expected 0", b, blank_errs);
        end
        tests_run++;
        if (bad_cnt !== int'(!exp[6])) begin
            tests_failed++;
            $display("[TB] FAIL single_bad_cnt(%h): got %0d expected %0d", b, bad_cnt, int'(!exp[6]));
        end
        if (!exp[6]) begin
            tests_run++;
            if (bad_edge - n !== 1 || bad_len_max !== 1) begin
                tests_failed++;
                $display("[TB] FAIL single_bad_timing(%h): got edge %0d len %0d expected edge 1 len 1", b, bad_edge - n, bad_len_max);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [6:0] exp;
        int         n;
        q.push_back(8'h63);
        q.push_back(8'h6A);
        q.push_back(8'h77);
        clear_mon();
        push_bytes(q, n);
        wait_idle(200);
        tests_run++;
        if (cells.size() !== 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: got %0d cells expected 3", cells.size());
        end else begin
            foreach (cells[i]) begin
                exp = ref_cell(q[i]);
                tests_run++;
                if (cells[i].dots !== exp[5:0] || cells[i].hold !== HOLD || cells[i].done_cnt !== 1) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_cell%0d: got dots %b hold %0d done %0d expected %b %0d 1", i, cells[i].dots, cells[i].hold, cells[i].done_cnt, exp[5:0], HOLD);
                end
                if (i > 0) begin
                    tests_run++;
                    if (cells[i].start_edge - cells[i-1].start_edge !== HOLD + GAP + 1) begin
                        tests_failed++;
                        $display("[TB] FAIL b2b_period%0d: got %0d expected %0d", i, cells[i].start_edge - cells[i-1].start_edge, HOLD + GAP + 1);
                    end
                end
            end
        end
        tests_run++;
        if (o_overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_overflow: got %0b expected 0", o_overflow);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [5:0] exp_q[$];
        logic [6:0] c;
        logic [7:0] b;
        int         exp_bad;
        int         len;
        int         sel;
        int         n;
        int         ok;
        for (int r = 0; r < 8; r++) begin
            q.delete();
            exp_q.delete();
            exp_bad = 0;
            len = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < len; i++) begin
                sel = $urandom_range(0, 9);
                if (sel < 4)      b = 8'h61 + 8'($urandom_range(0, 25));
                else if (sel < 7) b = 8'h41 + 8'($urandom_range(0, 25));
                else              b = 8'($urandom_range(0, 255));
                q.push_back(b);
                c = ref_cell(b);
                exp_q.push_back(c[5:0]);
                if (!c[6]) exp_bad++;
            end
            clear_mon();
            push_bytes(q, n);
            wait_idle(300);
            tests_run++;
            if (cells.size() !== len) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_count: got %0d cells expected %0d", r, cells.size(), len);
            end else begin
                ok = 1;
                foreach (cells[i]) begin
                    if (cells[i].dots !== exp_q[i] || cells[i].hold !== HOLD || cells[i].done_cnt !== 1) begin
                        ok = 0;
                        $display("[TB] FAIL rand%0d_cell%0d: byte %h got %b hold %0d expected %b hold %0d", r, i, q[i], cells[i].dots, cells[i].hold, exp_q[i], HOLD);
                    end
                end
                tests_run++;
                if (ok == 0) tests_failed++;
            end
            tests_run++;
            if (bad_cnt !== exp_bad || o_overflow !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_flags: got bad %0d ovf %0b expected bad %0d ovf 0", r, bad_cnt, o_overflow, exp_bad);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        logic [6:0] exp;
        int         n;
        clear_mon();
        q.push_back(8'h61);
        push_bytes(q, n);
        wait_en(10);
        q.delete();
        for (int i = 1; i <= DEPTH; i++) q.push_back(8'h61 + 8'(i));
        push_bytes(q, n);
        tests_run++;
        if (o_overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_fill: got %0b expected 0 with queue just full", o_overflow);
        end
        q.delete();
        q.push_back(8'h66);
        push_bytes(q, n);
        tests_run++;
        if (o_overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_set: got %0b expected 1", o_overflow);
        end
        wait_idle(300);
        tests_run++;
        if (cells.size() !== DEPTH + 1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_count: got %0d cells expected %0d", cells.size(), DEPTH + 1);
        end else begin
            foreach (cells[i]) begin
                exp = ref_cell(8'h61 + 8'(i));
                tests_run++;
                if (cells[i].dots !== exp[5:0]) begin
                    tests_failed++;
                    $display("[TB] FAIL ovf_cell%0d: got %b expected %b", i, cells[i].dots, exp[5:0]);
                end
            end
        end
        tests_run++;
        if (o_overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_sticky: got %0b expected 1", o_overflow);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tests_run++;
        if (o_overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_clear: got %0b expected 0 after reset", o_overflow);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [7:0] q[$];
        int         n;
        int         sz;
        clear_mon();
        q.push_back(8'h61);
        q.push_back(8'h62);
        q.push_back(8'h63);
        push_bytes(q, n);
        wait_en(10);
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        tests_run++;
        if ({o_dots, o_dot_en, o_char_done, o_busy, o_bad_char, o_overflow} !== 11'b0) begin
            tests_failed++;
            $display("[TB] FAIL midhold_reset: outputs=%b expected 0", {o_dots, o_dot_en, o_char_done, o_busy, o_bad_char, o_overflow});
        end
        reset_n = 1'b1;
        tick();
        sz = cells.size();
        repeat (40) tick();
        tests_run++;
        if (cells.size() !== sz || o_busy !== 1'b0 || o_dot_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midhold_discard: got %0d new cells busy %0b en %0b expected 0 0 0", cells.size() - sz, o_busy, o_dot_en);
        end
    endtask

    initial begin
        test_reset();
        test_single_cell(8'h61);
        test_single_cell(8'h5A);
        test_single_cell(8'h37);
        test_back_to_back();
        test_random();
        test_overflow();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
